// File: rtl/seven_seg_scan_n.sv
// Multiplexed seven-segment driver: periodic/forced snapshot of the digit bus,
// anode scan with dead time, leading-zero blanking and selectable polarity.
module seven_seg_scan_n #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 48000,
    parameter int HOLD_DIV   = 6000000,
    parameter int DEAD_CYC   = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic                    freeze,
    input  logic                    load_now,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    snap_tick
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HOLD_W = (HOLD_DIV > 1) ? $clog2(HOLD_DIV) : 1;
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    localparam logic                  POL_OFF = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{POL_OFF}};
    localparam logic [6:0]            SEG_OFF = {7{POL_OFF}};
    localparam logic [NUM_DIGITS-1:0] ONE_HOT = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    // Active-low segment pattern (bit6=g .. bit0=a) for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] pat;
        case (hex)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    logic [SCAN_W-1:0]              scan_cnt_r;
    logic [IDX_W-1:0]               digit_idx_r;
    logic [HOLD_W-1:0]              hold_cnt_r;
    logic [NUM_DIGITS-1:0][3:0]     snap_digits_r;
    logic [NUM_DIGITS-1:0]          snap_dp_r;
    logic                           snap_tick_r;
    logic [NUM_DIGITS-1:0]          an_r;
    logic [6:0]                     seg_r;
    logic                           dp_r;

    logic                           scan_wrap_s;
    logic                           idx_wrap_s;
    logic                           hold_term_s;
    logic                           load_s;
    logic [NUM_DIGITS:1]            zero_run_s;
    logic [NUM_DIGITS-1:0]          blank_s;
    logic [3:0]                     cur_hex_s;
    logic                           cur_dp_s;
    logic                           cur_blank_s;
    logic [NUM_DIGITS-1:0]          an_nxt_s;
    logic [6:0]                     seg_nxt_s;
    logic                           dp_nxt_s;

    assign scan_wrap_s = (scan_cnt_r == SCAN_W'(SCAN_DIV - 1));
    assign idx_wrap_s  = (digit_idx_r == IDX_W'(NUM_DIGITS - 1));
    assign hold_term_s = (hold_cnt_r == HOLD_W'(HOLD_DIV - 1));
    // A forced load and a terminal-count load on the same cycle merge into one.
    assign load_s      = load_now | (hold_term_s & ~freeze);

    // zero_run_s[k]: digit k and every digit above it are zero with no dp.
    assign zero_run_s[NUM_DIGITS] = 1'b1;
    for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lz
        assign zero_run_s[k] = zero_run_s[k+1] & (snap_digits_r[k] == 4'h0) & ~snap_dp_r[k];
    end
    assign blank_s = {zero_run_s[NUM_DIGITS-1:1] & {(NUM_DIGITS-1){blank_lz}}, 1'b0};

    assign cur_hex_s   = snap_digits_r[digit_idx_r];
    assign cur_dp_s    = snap_dp_r[digit_idx_r];
    assign cur_blank_s = blank_s[digit_idx_r];

    // Next anode/segment/dp values for the current scan position.
    always_comb begin
        an_nxt_s  = AN_OFF;
        seg_nxt_s = SEG_OFF;
        dp_nxt_s  = POL_OFF;
        if (cur_blank_s) begin
            an_nxt_s = AN_OFF;
        end else begin
            if (POL_OFF) begin
                seg_nxt_s = hex_to_seg(cur_hex_s);
            end else begin
                seg_nxt_s = ~hex_to_seg(cur_hex_s);
            end
            dp_nxt_s = cur_dp_s ? ~POL_OFF : POL_OFF;
            if (scan_cnt_r < SCAN_W'(DEAD_CYC)) begin
                an_nxt_s = AN_OFF;
            end else begin
                an_nxt_s = AN_OFF ^ (ONE_HOT << digit_idx_r);
            end
        end
    end

    // Digit slot counter and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_r  <= '0;
            digit_idx_r <= '0;
        end else if (scan_wrap_s) begin
            scan_cnt_r  <= '0;
            digit_idx_r <= idx_wrap_s ? '0 : digit_idx_r + IDX_W'(1);
        end else begin
            scan_cnt_r  <= scan_cnt_r + SCAN_W'(1);
        end
    end

    // Hold period counter; a forced load restarts the period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= '0;
        end else if (load_now || hold_term_s) begin
            hold_cnt_r <= '0;
        end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
        end
    end

    // Snapshot registers and the tick that follows each load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_digits_r <= '0;
            snap_dp_r     <= '0;
            snap_tick_r   <= 1'b0;
        end else begin
            snap_tick_r <= load_s;
            if (load_s) begin
                snap_digits_r <= digits_in;
                snap_dp_r     <= dp_in;
            end
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_OFF;
            dp_r  <= POL_OFF;
        end else begin
            an_r  <= an_nxt_s;
            seg_r <= seg_nxt_s;
            dp_r  <= dp_nxt_s;
        end
    end

    assign an        = an_r;
    assign seg       = seg_r;
    assign dp        = dp_r;
    assign snap_tick = snap_tick_r;

endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Scoreboard bench for seven_seg_scan_n: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the pins.
module tb_seven_seg_scan_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        freeze;
    logic        load_now;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        snap_tick;

    always #5 clk = ~clk;

    seven_seg_scan_n #(
        .NUM_DIGITS(4),
        .SCAN_DIV  (4),
        .HOLD_DIV  (20),
        .DEAD_CYC  (1),
        .ACTIVE_LOW(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .digits_in(digits_in),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .freeze   (freeze),
        .load_now (load_now),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .snap_tick(snap_tick)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
        string      nm;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          e = 0;
    logic [15:0] m_dig = 16'h0000;
    logic [3:0]  m_dp = 4'h0;
    string       phase = "reset";

    function automatic logic [6:0] hex_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  4'hF: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string nm, input string what, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", nm, what, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk(x.nm, "an",   {4'h0, an},        {4'h0, x.an});
            chk(x.nm, "seg",  {1'b0, seg},       {1'b0, x.seg});
            chk(x.nm, "dp",   {7'h00, dp},       {7'h00, x.dp});
            chk(x.nm, "tick", {7'h00, snap_tick}, {7'h00, x.tick});
        end
    end

    // Expect the reset/inactive pin state for the cycle after the next edge.
    task automatic step_rst();
        exp_t x;
        @(posedge clk);
        #1;
        x.an = 4'hF; x.seg = 7'h7F; x.dp = 1'b1; x.tick = 1'b0; x.nm = phase;
        exp_q.push_back(x);
    endtask

    // One clock edge of normal scanning; load_exp marks a hand-scheduled snapshot edge.
    task automatic step(input bit load_exp);
        exp_t        x;
        int          ph;
        int          dg;
        bit          blank;
        logic [15:0] sh;
        logic [3:0]  dsh;
        @(posedge clk);
        #1;
        e++;
        ph = (e - 1) % 4;
        dg = ((e - 1) / 4) % 4;
        blank = 1'b0;
        if (blank_lz && dg > 0) begin
            blank = 1'b1;
            for (int k = dg; k < 4; k++) begin
                sh  = m_dig >> (4 * k);
                dsh = m_dp >> k;
                if (sh[3:0] != 4'h0 || dsh[0]) blank = 1'b0;
            end
        end
        sh  = m_dig >> (4 * dg);
        dsh = m_dp >> dg;
        x.an   = (ph == 0 || blank) ? 4'hF : ~(4'b0001 << dg);
        x.seg  = blank ? 7'h7F : hex_seg(sh[3:0]);
        x.dp   = blank ? 1'b1 : ~dsh[0];
        x.tick = load_exp;
        x.nm   = phase;
        exp_q.push_back(x);
        if (load_exp) begin
            m_dig = digits_in;
            m_dp  = dp_in;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t x;
        digits_in = 16'h0000; dp_in = 4'h0; blank_lz = 1'b0; freeze = 1'b0; load_now = 1'b0;
        #2 rst_n = 1'b0;
        phase = "reset";
        repeat (3) step_rst();
        rst_n = 1'b1;
        e = 0; m_dig = 16'h0000; m_dp = 4'h0;

        // Idle scan of zeros; new inputs stay invisible until the hold wrap.
        phase = "idle";
        steps(2);
        digits_in = 16'h12AF; dp_in = 4'b0100;
        steps(17);
        phase = "snap";
        step(1'b1);                                 // edge 20: hold terminal
        steps(16);

        // Frozen for three hold periods, then a forced load.
        phase = "freeze";
        freeze = 1'b1; digits_in = 16'h0005; dp_in = 4'h0;
        steps(60);
        phase = "load_now";
        load_now = 1'b1;
        step(1'b1);                                 // edge 97
        load_now = 1'b0; freeze = 1'b0; blank_lz = 1'b1; digits_in = 16'h0050;
        steps(19);
        phase = "hold_restart";
        step(1'b1);                                 // edge 117: 20 after the forced load

        // Leading-zero blanking with and without a dp on the top digit.
        phase = "lz";
        steps(7);
        dp_in = 4'b1000;
        steps(12);
        phase = "lz_dp";
        step(1'b1);                                 // edge 137
        steps(17);                                  // ends on digit 2, anode active

        // Asynchronous reset between edges in the digit-2 slot.
        phase = "async_rst";
        @(posedge clk);
        #1;
        x.an = 4'hF; x.seg = 7'h7F; x.dp = 1'b1; x.tick = 1'b0; x.nm = phase;
        exp_q.push_back(x);
        #1 rst_n = 1'b0;
        repeat (2) step_rst();
        rst_n = 1'b1;
        e = 0; m_dig = 16'h0000; m_dp = 4'h0;

        phase = "after_rst";
        steps(19);
        phase = "collision";
        load_now = 1'b1;
        step(1'b1);                                 // edge 20: terminal and load_now together
        load_now = 1'b0; digits_in = 16'h3C00; dp_in = 4'h0;
        steps(19);
        phase = "post_collision";
        step(1'b1);                                 // edge 40
        steps(8);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
